// File: rtl/interpolator_pkg.sv
// interpolator_pkg: shared types and constants for the linear-interpolating upsampler.
//   state_e              - control state (empty / idle / run)
//   WordLengthDefault    - default sample width
//   Log2FactorDefault    - default interpolation exponent
//   L                    - default interpolation factor, 1 << Log2FactorDefault
//   diff_width()         - width of cur - prev for a given sample width
//   prod_width()         - width of k * d for a given sample width and exponent
package interpolator_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,  // no sample seen yet since reset
        StIdle  = 2'd1,  // prev valid, waiting for the next sample
        StRun   = 2'd2   // emitting the L interpolated outputs of a segment
    } state_e;

    localparam int unsigned WordLengthDefault = 8;
    localparam int unsigned Log2FactorDefault = 2;
    localparam int unsigned L                 = 1 << Log2FactorDefault;

    // cur - prev needs one extra bit to hold the full signed range.
    function automatic int unsigned diff_width(input int unsigned word_length);
        return word_length + 1;
    endfunction

    // k < 2^log2_factor, so the product grows by log2_factor bits.
    function automatic int unsigned prod_width(input int unsigned word_length,
                                               input int unsigned log2_factor);
        return word_length + 1 + log2_factor;
    endfunction

    localparam int unsigned DiffWidthDefault = WordLengthDefault + 1;
    localparam int unsigned ProdWidthDefault = WordLengthDefault + 1 + Log2FactorDefault;

endpackage

// File: rtl/interpolator_phase_mac.sv
// interpolator_phase_mac: combinational interpolation point
//   y = prev + ((k * (cur - prev)) >>> log2_factor)
// Ports:
//   prev  in  word_length  segment start sample (signed)
//   cur   in  word_length  segment end sample (signed)
//   k     in  log2_factor  phase within the segment (unsigned)
//   y     out word_length  interpolated sample (signed)
module interpolator_phase_mac
    import interpolator_pkg::*;
#(
    parameter int unsigned word_length = 8,
    parameter int unsigned log2_factor = 2
) (
    input  logic signed [word_length-1:0] prev,
    input  logic signed [word_length-1:0] cur,
    input  logic        [log2_factor-1:0] k,
    output logic signed [word_length-1:0] y
);

    localparam int unsigned DW = diff_width(word_length);
    localparam int unsigned PW = prod_width(word_length, log2_factor);

    logic signed [DW-1:0] d;
    logic signed [PW-1:0] k_x;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] sum;

    always_comb begin
        d   = DW'(cur) - DW'(prev);
        // Zero-extend the phase so the multiply stays signed.
        k_x = {{(PW - log2_factor){1'b0}}, k};
        p   = PW'(d) * k_x;
        // Arithmetic shift rounds toward minus infinity. The sum lies between
        // prev and cur, so truncating back to word_length is exact.
        sum = PW'(prev) + (p >>> log2_factor);
        y   = word_length'(sum);
    end

endmodule

// File: rtl/interpolator_1.sv
// interpolator_1: linear-interpolating upsampler. Each accepted sample yields
// 2^log2_factor outputs spaced linearly from the previous sample toward it.
// Ports:
//   clock      in   positive-edge clock
//   reset      in   asynchronous active-high reset
//   data_in    in   signed input sample
//   in_valid   in   data_in valid
//   in_ready   out  combinational; block accepts data_in this cycle
//   hold       in   freezes all state and suppresses output
//   data_out   out  registered interpolated sample
//   out_valid  out  one-cycle strobe per new data_out value
module interpolator_1
    import interpolator_pkg::*;
#(
    parameter int unsigned word_length = 8,
    parameter int unsigned log2_factor = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic signed [word_length-1:0] data_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          hold,
    output logic signed [word_length-1:0] data_out,
    output logic                          out_valid
);

    localparam logic [log2_factor-1:0] KLast = '1;

    state_e                        state_q, state_d;
    logic signed [word_length-1:0] prev_q, prev_d;
    logic signed [word_length-1:0] cur_q, cur_d;
    logic        [log2_factor-1:0] k_q, k_d;
    logic signed [word_length-1:0] data_out_q, data_out_d;
    logic                          out_valid_q, out_valid_d;

    logic signed [word_length-1:0] y;
    logic                          accept;

    interpolator_phase_mac #(
        .word_length (word_length),
        .log2_factor (log2_factor)
    ) u_phase_mac (
        .prev (prev_q),
        .cur  (cur_q),
        .k    (k_q),
        .y    (y)
    );

    // Ready opens in the last phase of a segment so streams run without bubbles.
    assign in_ready = !hold && ((state_q != StRun) || (k_q == KLast));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        k_d         = k_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;

        if (!hold) begin
            unique case (state_q)
                StEmpty: begin
                    // First sample only primes the start point.
                    if (accept) begin
                        prev_d  = data_in;
                        state_d = StIdle;
                    end
                end
                StIdle: begin
                    if (accept) begin
                        cur_d   = data_in;
                        k_d     = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    data_out_d  = y;
                    out_valid_d = 1'b1;
                    k_d         = k_q + 1'b1;
                    if (k_q == KLast) begin
                        prev_d = cur_q;
                        if (accept) begin
                            cur_d = data_in;
                            k_d   = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StEmpty;
            prev_q      <= '0;
            cur_q       <= '0;
            k_q         <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            k_q         <= k_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_interpolator_1.sv
module tb_interpolator_1;

    logic              clock;
    logic              reset;
    logic signed [7:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic              hold;
    logic signed [7:0] data_out;
    logic              out_valid;

    int checks = 0;
    int errors = 0;

    interpolator_1 #(
        .word_length (8),
        .log2_factor (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hold      (hold),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic              rst;
        logic              vld;
        logic signed [7:0] din;
        logic              hld;
        logic              exp_rdy;
        logic              exp_ov;
        logic signed [7:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic vld, input int din,
                                input logic hld, input logic exp_rdy, input logic exp_ov,
                                input int exp_dout);
        vec_t v;
        v.rst      = rst;
        v.vld      = vld;
        v.din      = 8'(din);
        v.hld      = hld;
        v.exp_rdy  = exp_rdy;
        v.exp_ov   = exp_ov;
        v.exp_dout = 8'(exp_dout);
        return v;
    endfunction

    task automatic check_bit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic check_word(input string nm, input logic signed [7:0] got,
                              input logic signed [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Drive at negedge, check ready before the edge, check outputs after it.
    task automatic step(input string nm, input vec_t v);
        @(negedge clock);
        reset    = v.rst;
        in_valid = v.vld;
        data_in  = v.din;
        hold     = v.hld;
        #1;
        check_bit({nm, " in_ready"}, in_ready, v.exp_rdy);
        @(posedge clock);
        #1;
        check_bit({nm, " out_valid"}, out_valid, v.exp_ov);
        check_word({nm, " data_out"}, data_out, v.exp_dout);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        hold     = 1'b0;

        //                rst vld  din hld rdy ov  dout
        // Continuous stream 0, 8, -8.
        vecs.push_back(mk(1, 0,    0, 0, 1, 0,    0));
        vecs.push_back(mk(0, 1,    0, 0, 1, 0,    0));
        vecs.push_back(mk(0, 1,    8, 0, 1, 0,    0));
        vecs.push_back(mk(0, 1,   -8, 0, 0, 1,    0));
        vecs.push_back(mk(0, 1,   -8, 0, 0, 1,    2));
        vecs.push_back(mk(0, 1,   -8, 0, 0, 1,    4));
        vecs.push_back(mk(0, 1,   -8, 0, 1, 1,    6));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,    8));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,    4));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,    0));
        vecs.push_back(mk(0, 0,    0, 0, 1, 1,   -4));
        vecs.push_back(mk(0, 0,    0, 0, 1, 0,   -4));
        // Floor rounding: 0 -> -1.
        vecs.push_back(mk(1, 0,    0, 0, 1, 0,    0));
        vecs.push_back(mk(0, 1,    0, 0, 1, 0,    0));
        vecs.push_back(mk(0, 1,   -1, 0, 1, 0,    0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,    0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,   -1));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,   -1));
        vecs.push_back(mk(0, 0,    0, 0, 1, 1,   -1));
        // Gap: back in idle, next sample outputs one cycle after accept.
        vecs.push_back(mk(0, 0,    0, 0, 1, 0,   -1));
        vecs.push_back(mk(0, 1,    3, 0, 1, 0,   -1));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,   -1));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,    0));
        // Hold for 3 cycles after k=1, then k=2 and k=3.
        vecs.push_back(mk(0, 1,    5, 1, 0, 0,    0));
        vecs.push_back(mk(0, 1,    5, 1, 0, 0,    0));
        vecs.push_back(mk(0, 1,    5, 1, 0, 0,    0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,    1));
        vecs.push_back(mk(0, 0,    0, 0, 1, 1,    2));
        vecs.push_back(mk(0, 0,    0, 0, 1, 0,    2));
        // Extremes 127 -> -128.
        vecs.push_back(mk(1, 0,    0, 0, 1, 0,    0));
        vecs.push_back(mk(0, 1,  127, 0, 1, 0,    0));
        vecs.push_back(mk(0, 1, -128, 0, 1, 0,    0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  127));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,   63));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,   -1));
        vecs.push_back(mk(0, 0,    0, 0, 1, 1,  -65));
        // Hold in idle ignores in_valid.
        vecs.push_back(mk(0, 1,    5, 1, 0, 0,  -65));
        vecs.push_back(mk(0, 0,    0, 0, 1, 0,  -65));
        // Reset and hold together: reset wins, ready stays low under hold.
        vecs.push_back(mk(1, 1,    9, 1, 0, 0,    0));
        vecs.push_back(mk(0, 0,    0, 0, 1, 0,    0));

        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

        // Reset mid-RUN clears outputs without waiting for a clock edge.
        step("mr0", mk(0, 1, 0, 0, 1, 0, 0));
        step("mr1", mk(0, 1, 8, 0, 1, 0, 0));
        step("mr2", mk(0, 0, 0, 0, 0, 1, 0));
        step("mr3", mk(0, 0, 0, 0, 0, 1, 2));
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_bit("async_rst out_valid", out_valid, 1'b0);
        check_word("async_rst data_out", data_out, 8'sd0);
        check_bit("async_rst in_ready", in_ready, 1'b1);
        // After reset, the block must be primed again: 0 then 8 -> 0, 2, 4, 6.
        step("rp0", mk(1, 0, 0, 0, 1, 0, 0));
        step("rp1", mk(0, 1, 0, 0, 1, 0, 0));
        step("rp2", mk(0, 1, 8, 0, 1, 0, 0));
        step("rp3", mk(0, 0, 0, 0, 0, 1, 0));
        step("rp4", mk(0, 0, 0, 0, 0, 1, 2));
        step("rp5", mk(0, 0, 0, 0, 0, 1, 4));
        step("rp6", mk(0, 0, 0, 0, 1, 1, 6));
        step("rp7", mk(0, 0, 0, 0, 1, 0, 6));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interpolator_1.md
# interpolator_1

Linear-interpolating upsampler for the DSP chapter sample-rate chain. It is the counterpart to the decimator and sits on the upsampling path. Each accepted input sample produces L = 2^log2_factor output samples, linearly spaced from the previous input sample toward the new one. Input uses a valid/ready handshake. Output is a registered word with a one-cycle valid strobe per new sample. An active-high hold freezes the block.

## Interface
- word_length, 8: sample width; samples are signed two's complement.
- log2_factor, 2: interpolation factor exponent, L = 2^log2_factor; legal range is 1..4.
- clock  input  1  positive-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  word_length  input sample.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  combinational; block accepts data_in this cycle.
- hold  input  1  active high; freezes all state, suppresses new output.
- data_out  output  word_length  registered interpolated sample.
- out_valid  output  1  registered; high for one cycle per new data_out value.

## Operation
- Registers:
  - prev and cur, word_length each.
  - phase k, log2_factor bits.
  - state: one of EMPTY, IDLE, RUN.
  - data_out and out_valid.
- Accept = in_valid & in_ready & !hold.
- in_ready = !hold & (state != RUN | k == L-1).
- EMPTY: on accept, prev <= data_in and go to IDLE. No output is produced; the first sample only primes the block.
- IDLE: on accept, cur <= data_in, k <= 0, go to RUN.
- RUN (!hold), each cycle:
  - data_out <= y_k; out_valid <= 1; k <= k+1 (wraps).
  - At k == L-1, prev <= cur.
  - At k == L-1 with accept: cur <= data_in, k <= 0, stay in RUN (seamless streaming).
  - At k == L-1 without accept: go to IDLE.
- Arithmetic:
  - d = cur - prev, word_length+1 bits, signed.
  - p = k * d, word_length+1+log2_factor bits, signed.
  - y_k = prev + (p >>> log2_factor), arithmetic shift, so rounding is floor.
  - The result lies between prev and cur, so it always fits in word_length bits and no saturation is needed.
- out_valid <= 0 in every cycle that loads no new y_k, including EMPTY, IDLE and hold.
- hold = 1: all registers keep their value except out_valid, which clears. in_ready = 0. in_valid is ignored.

## Timing
- Reset (asynchronous, effective immediately, including mid-RUN):
  - state EMPTY; prev, cur, k = 0; data_out = 0; out_valid = 0.
  - in_ready = 1 once hold is low.
- Latency: sample accepted at edge t (block in IDLE). y_0 = prev appears at edge t+1, y_{L-1} at edge t+L.
- Streaming with in_valid held high:
  - One output per cycle.
  - in_ready high one cycle in L.
  - No bubble between interpolation segments.
- in_valid low at k == L-1: the block drops to IDLE. The next accept resumes output one cycle after that accept.
- hold asserted mid-RUN: k is frozen. The sequence resumes at the same k the cycle after hold drops, with no lost or duplicated output.
- hold and reset together: reset wins.

## Structure
- Package interpolator_pkg holds:
  - the state enum (EMPTY, IDLE, RUN);
  - localparam L = 1 << log2_factor;
  - width helper constants for the d and p widths.
- One sub-module is natural: interpolator_phase_mac, a combinational block computing y_k from prev, cur and k, parameterised by word_length and log2_factor.
- Control, registers and handshake stay in the top module.

## Test plan
- Reset/prime: assert reset mid-stream.
  - data_out = 0 and out_valid = 0 immediately.
  - Then feed 0, then 8 (L=4): no output for the first sample; outputs 0, 2, 4, 6 on consecutive cycles.
- Continuous stream: samples 0, 8, -8 with in_valid held high.
  - Outputs 0, 2, 4, 6, 8, 4, 0, -4 back-to-back.
  - in_ready pulses once per 4 cycles.
- Floor rounding: prev 0, cur -1 → 0, -1, -1, -1.
- Extremes: prev 127, cur -128 (word_length 8) → 127, 63, -1, -65, with no overflow.
- Hold: assert hold 3 cycles after output k=1.
  - out_valid is 0 and data_out holds for those 3 cycles.
  - in_ready stays low.
  - Then k=2 and k=3 follow, with no skip or repeat.
- Gap: in_valid low at k == L-1.
  - The block returns to IDLE with out_valid 0.
  - A later sample produces its first output one cycle after accept.
